// File: rtl/csr_snapshot_streamer_if.sv
// Valid/ready beat stream carrying one 64-bit CSR snapshot field per transfer.
interface csr_snapshot_streamer_if;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_index;
  logic [63:0] out_data;
  logic        out_last;

  modport master (
    output out_valid,
    output out_index,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_index,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/csr_snapshot_streamer.sv
// Snapshots all 29 CSRPack fields on capture and streams the enabled ones out,
// one field per beat. csr_in[i] is the field with declaration index i.
module csr_snapshot_streamer #(
  parameter logic [28:0] FIELD_MASK = 29'h1FFF_FFFF,
  parameter int          DROP_W     = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    capture,
  input  logic [28:0][63:0]       csr_in,
  csr_snapshot_streamer_if.master stream,
  output logic                    busy,
  output logic                    done,
  output logic [DROP_W-1:0]       drop_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam int NUM_FIELDS = 29;

  // Lowest enabled field strictly above idx (0 when there is none).
  function automatic logic [4:0] next_set_f(input int idx);
    logic [4:0] r;
    r = '0;
    for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
      if (FIELD_MASK[i] && (i > idx)) r = 5'(i);
    end
    return r;
  endfunction

  function automatic logic has_higher_f(input int idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (FIELD_MASK[i] && (i > idx)) r = 1'b1;
    end
    return r;
  endfunction

  localparam logic [4:0] FIRST_IDX  = next_set_f(-1);
  localparam logic       FIRST_LAST = !has_higher_f(int'(FIRST_IDX));
  localparam logic       MASK_EMPTY = (FIELD_MASK == '0);

  // Successor and last-flag per index are mask constants, so skipping costs no cycles.
  logic [4:0]  next_tbl [32];
  logic [31:0] last_tbl;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_tbl
      assign next_tbl[gi] = next_set_f(gi);
      assign last_tbl[gi] = !has_higher_f(gi);
    end
  endgenerate

  logic [0:0]        state_reg, state_next;
  logic              out_valid_reg, out_valid_next;
  logic [4:0]        out_index_reg, out_index_next;
  logic [63:0]       out_data_reg, out_data_next;
  logic              out_last_reg, out_last_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic [DROP_W-1:0] drop_cnt_reg, drop_cnt_next;
  logic [28:0][63:0] snapshot_reg;

  logic       hs;
  logic       last_hs;
  logic       accept;
  logic [4:0] adv_idx;

  assign hs      = out_valid_reg & stream.out_ready;
  assign last_hs = hs & out_last_reg;
  // The final handshake frees the stream in the same cycle, so a capture there is taken.
  assign accept  = capture & ((state_reg == IDLE) | last_hs);
  assign adv_idx = next_tbl[out_index_reg];

  always_comb begin
    state_next     = state_reg;
    out_valid_next = out_valid_reg;
    out_index_next = out_index_reg;
    out_data_next  = out_data_reg;
    out_last_next  = out_last_reg;
    done_next      = 1'b0;
    drop_cnt_next  = drop_cnt_reg;

    if (accept) begin
      if (MASK_EMPTY) begin
        state_next     = IDLE;
        out_valid_next = 1'b0;
        out_index_next = '0;
        out_data_next  = '0;
        out_last_next  = 1'b0;
        done_next      = 1'b1;
      end else begin
        state_next     = SEND;
        out_valid_next = 1'b1;
        out_index_next = FIRST_IDX;
        out_data_next  = csr_in[FIRST_IDX];
        out_last_next  = FIRST_LAST;
      end
      if (last_hs) done_next = 1'b1;
    end else if (last_hs) begin
      state_next     = IDLE;
      out_valid_next = 1'b0;
      out_index_next = '0;
      out_data_next  = '0;
      out_last_next  = 1'b0;
      done_next      = 1'b1;
    end else if (hs) begin
      out_index_next = adv_idx;
      out_data_next  = snapshot_reg[adv_idx];
      out_last_next  = last_tbl[adv_idx];
    end

    if (capture && !accept && (drop_cnt_reg != '1)) begin
      drop_cnt_next = drop_cnt_reg + DROP_W'(1);
    end

    busy_next = (state_next == SEND);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
      out_index_reg <= '0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      drop_cnt_reg  <= '0;
      snapshot_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= out_valid_next;
      out_index_reg <= out_index_next;
      out_data_reg  <= out_data_next;
      out_last_reg  <= out_last_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      drop_cnt_reg  <= drop_cnt_next;
      if (accept) snapshot_reg <= csr_in;
    end
  end

  assign stream.out_valid = out_valid_reg;
  assign stream.out_index = out_index_reg;
  assign stream.out_data  = out_data_reg;
  assign stream.out_last  = out_last_reg;
  assign busy             = busy_reg;
  assign done             = done_reg;
  assign drop_cnt         = drop_cnt_reg;

endmodule

// File: tb/tb_csr_snapshot_streamer.sv
// Randomized bench for csr_snapshot_streamer: full, sparse and empty field masks
// checked against a beat-list model built from the mask and the captured snapshot.
module tb_csr_snapshot_streamer;

  localparam logic [28:0] MASK_F = 29'h1FFF_FFFF;
  localparam logic [28:0] MASK_S = 29'h0000_0101;
  localparam logic [28:0] MASK_E = 29'h0000_0000;

  logic clk = 1'b0;
  logic rstn;
  logic [28:0][63:0] csr_in;
  logic cap_f, cap_s, cap_e;
  logic busy_f, done_f, busy_s, done_s, busy_e, done_e;
  logic [7:0] drop_f, drop_s, drop_e;

  csr_snapshot_streamer_if if_f ();
  csr_snapshot_streamer_if if_s ();
  csr_snapshot_streamer_if if_e ();

  csr_snapshot_streamer #(.FIELD_MASK(MASK_F), .DROP_W(8)) dut_f (
    .clk(clk), .rstn(rstn), .capture(cap_f), .csr_in(csr_in), .stream(if_f),
    .busy(busy_f), .done(done_f), .drop_cnt(drop_f)
  );
  csr_snapshot_streamer #(.FIELD_MASK(MASK_S), .DROP_W(8)) dut_s (
    .clk(clk), .rstn(rstn), .capture(cap_s), .csr_in(csr_in), .stream(if_s),
    .busy(busy_s), .done(done_s), .drop_cnt(drop_s)
  );
  csr_snapshot_streamer #(.FIELD_MASK(MASK_E), .DROP_W(8)) dut_e (
    .clk(clk), .rstn(rstn), .capture(cap_e), .csr_in(csr_in), .stream(if_e),
    .busy(busy_e), .done(done_e), .drop_cnt(drop_e)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  logic [28:0][63:0] snap;
  int exp_drop = 0;

  // Model: the beats a capture should produce are the set mask bits in ascending order.
  task automatic load_beats(input logic [28:0] mask);
    exp_q.delete();
    for (int i = 0; i < 29; i++) if (mask[i]) exp_q.push_back(i);
  endtask

  task automatic rand_csr();
    for (int i = 0; i < 29; i++) csr_in[i] = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    logic [80:0] got;
    rstn = 1'b1; cap_f = 0; cap_s = 0; cap_e = 0;
    if_f.out_ready = 0; if_s.out_ready = 0; if_e.out_ready = 0;
    rand_csr();
    #3 rstn = 1'b0;
    @(negedge clk);
    got = {if_f.out_valid, if_f.out_index, if_f.out_data, if_f.out_last, busy_f, done_f, drop_f};
    n_cmp++;
    if (got !== '0) begin
      n_bad++; $display("FAIL reset_full got %h want 0", got);
    end
    got = {if_s.out_valid, if_s.out_index, if_s.out_data, if_s.out_last, busy_s, done_s, drop_s};
    n_cmp++;
    if (got !== '0) begin
      n_bad++; $display("FAIL reset_sparse got %h want 0", got);
    end
    rstn = 1'b1;
    @(negedge clk);
    $display("reset: outputs checked after reset");
  endtask

  task automatic test_full_stream();
    logic [72:0] got, want;
    int b;
    rand_csr(); csr_in[8] = 64'hA00000000; snap = csr_in; load_beats(MASK_F);
    if_f.out_ready = 1; cap_f = 1;
    @(negedge clk);
    cap_f = 0; b = 0;
    while (exp_q.size() > 0 && b < 40) begin
      got  = {if_f.out_valid, if_f.out_index, if_f.out_data, if_f.out_last, busy_f, done_f};
      want = {1'b1, 5'(exp_q[0]), snap[exp_q[0]], exp_q.size() == 1, 1'b1, 1'b0};
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL full_beat%0d got %h want %h", exp_q[0], got, want);
      end
      if (exp_q[0] == 8) begin
        n_cmp++;
        if (if_f.out_data !== 64'hA00000000) begin
          n_bad++; $display("FAIL full_mstatus got %h want a00000000", if_f.out_data);
        end
      end
      $display("full: beat idx=%0d data=%h last=%0b", if_f.out_index, if_f.out_data, if_f.out_last);
      void'(exp_q.pop_front()); b++;
      @(negedge clk);
    end
    n_cmp++;
    if ({if_f.out_valid, busy_f, done_f} !== 3'b001) begin
      n_bad++; $display("FAIL full_done got %b want 001", {if_f.out_valid, busy_f, done_f});
    end
    @(negedge clk);
    n_cmp++;
    if (done_f !== 1'b0) begin
      n_bad++; $display("FAIL full_done_pulse got %b want 0", done_f);
    end
  endtask

  task automatic test_sparse_mask();
    logic [72:0] got, want;
    int b;
    rand_csr(); snap = csr_in; load_beats(MASK_S);
    if_s.out_ready = 1; cap_s = 1;
    @(negedge clk);
    cap_s = 0; b = 0;
    while (exp_q.size() > 0 && b < 10) begin
      got  = {if_s.out_valid, if_s.out_index, if_s.out_data, if_s.out_last, busy_s, done_s};
      want = {1'b1, 5'(exp_q[0]), snap[exp_q[0]], exp_q.size() == 1, 1'b1, 1'b0};
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL sparse_beat%0d got %h want %h", exp_q[0], got, want);
      end
      $display("sparse: beat idx=%0d last=%0b", if_s.out_index, if_s.out_last);
      void'(exp_q.pop_front()); b++;
      @(negedge clk);
    end
    n_cmp++;
    if ({if_s.out_valid, busy_s, done_s} !== 3'b001) begin
      n_bad++; $display("FAIL sparse_done got %b want 001", {if_s.out_valid, busy_s, done_s});
    end
    if_s.out_ready = 0;
  endtask

  task automatic test_empty_mask();
    cap_e = 1;
    @(negedge clk);
    cap_e = 0;
    n_cmp++;
    if ({if_e.out_valid, busy_e, done_e} !== 3'b001) begin
      n_bad++; $display("FAIL empty_done got %b want 001", {if_e.out_valid, busy_e, done_e});
    end
    @(negedge clk);
    n_cmp++;
    if ({if_e.out_valid, busy_e, done_e} !== 3'b000) begin
      n_bad++; $display("FAIL empty_idle got %b want 000", {if_e.out_valid, busy_e, done_e});
    end
    $display("empty: capture with no enabled fields, done=%0b", done_e);
  endtask

  task automatic test_stall_random();
    logic [72:0] got, want;
    int cyc;
    logic r;
    for (int round = 0; round < 2; round++) begin
      rand_csr(); snap = csr_in; load_beats(MASK_F);
      if_f.out_ready = 0; cap_f = 1;
      @(negedge clk);
      cap_f = 0; cyc = 0;
      while (exp_q.size() > 0 && cyc < 400) begin
        got  = {if_f.out_valid, if_f.out_index, if_f.out_data, if_f.out_last, busy_f, done_f};
        want = {1'b1, 5'(exp_q[0]), snap[exp_q[0]], exp_q.size() == 1, 1'b1, 1'b0};
        n_cmp++;
        if (got !== want) begin
          n_bad++; $display("FAIL stall_beat%0d got %h want %h", exp_q[0], got, want);
        end
        r = 1'($urandom_range(0, 1));
        if_f.out_ready = r;
        if (r) void'(exp_q.pop_front());
        rand_csr();
        cyc++;
        @(negedge clk);
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_bad++; $display("FAIL stall_timeout got %0d beats left want 0", exp_q.size());
      end
      n_cmp++;
      if ({if_f.out_valid, done_f} !== 2'b01) begin
        n_bad++; $display("FAIL stall_done got %b want 01", {if_f.out_valid, done_f});
      end
      $display("stall: round %0d finished after %0d cycles", round, cyc);
    end
    if_f.out_ready = 1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [72:0] got, want;
    logic [77:0] got2, want2;
    int cyc;
    rand_csr(); snap = csr_in; load_beats(MASK_F);
    if_f.out_ready = 1; cap_f = 1;
    @(negedge clk);
    cap_f = 0; cyc = 0;
    while (exp_q.size() > 1 && cyc < 40) begin
      void'(exp_q.pop_front()); cyc++;
      @(negedge clk);
    end
    n_cmp++;
    if ({if_f.out_valid, if_f.out_last, if_f.out_index} !== {2'b11, 5'd28}) begin
      n_bad++; $display("FAIL b2b_last got %b/%0d want 11/28", {if_f.out_valid, if_f.out_last}, if_f.out_index);
    end
    rand_csr(); snap = csr_in; load_beats(MASK_F);
    cap_f = 1;
    @(negedge clk);
    cap_f = 0;
    got2  = {if_f.out_valid, if_f.out_index, if_f.out_data, busy_f, done_f, drop_f};
    want2 = {1'b1, 5'd0, snap[0], 1'b1, 1'b1, 8'(exp_drop)};
    n_cmp++;
    if (got2 !== want2) begin
      n_bad++; $display("FAIL b2b_restart got %h want %h", got2, want2);
    end
    $display("b2b: restart idx=%0d data=%h done=%0b drop=%0d", if_f.out_index, if_f.out_data, done_f, drop_f);
    void'(exp_q.pop_front());
    @(negedge clk);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      got  = {if_f.out_valid, if_f.out_index, if_f.out_data, if_f.out_last, busy_f, done_f};
      want = {1'b1, 5'(exp_q[0]), snap[exp_q[0]], exp_q.size() == 1, 1'b1, 1'b0};
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL b2b_beat%0d got %h want %h", exp_q[0], got, want);
      end
      void'(exp_q.pop_front()); cyc++;
      @(negedge clk);
    end
    n_cmp++;
    if ({if_f.out_valid, done_f, drop_f} !== {2'b01, 8'(exp_drop)}) begin
      n_bad++; $display("FAIL b2b_end got %b/%0d want 01/%0d", {if_f.out_valid, done_f}, drop_f, exp_drop);
    end
  endtask

  task automatic test_drop_saturate();
    logic [72:0] got, want;
    int cyc;
    rand_csr(); snap = csr_in; load_beats(MASK_F);
    if_f.out_ready = 0; cap_f = 1;
    @(negedge clk);
    cap_f = 0;
    for (int k = 0; k < 300; k++) begin
      cap_f = 1; rand_csr();
      @(negedge clk);
      cap_f = 0;
      exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
      n_cmp++;
      if (drop_f !== 8'(exp_drop)) begin
        n_bad++; $display("FAIL drop_cnt%0d got %0d want %0d", k, drop_f, exp_drop);
      end
      n_cmp++;
      if ({if_f.out_valid, if_f.out_index, if_f.out_data} !== {1'b1, 5'd0, snap[0]}) begin
        n_bad++; $display("FAIL drop_hold got %0d/%h want 0/%h", if_f.out_index, if_f.out_data, snap[0]);
      end
      if (k % 50 == 49) $display("drop: %0d captures rejected, drop_cnt=%0d", k + 1, drop_f);
      @(negedge clk);
    end
    if_f.out_ready = 1; cyc = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      got  = {if_f.out_valid, if_f.out_index, if_f.out_data, if_f.out_last, busy_f, done_f};
      want = {1'b1, 5'(exp_q[0]), snap[exp_q[0]], exp_q.size() == 1, 1'b1, 1'b0};
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL drop_beat%0d got %h want %h", exp_q[0], got, want);
      end
      void'(exp_q.pop_front()); cyc++;
      @(negedge clk);
    end
    n_cmp++;
    if ({if_f.out_valid, done_f, drop_f} !== {2'b01, 8'd255}) begin
      n_bad++; $display("FAIL drop_end got %b/%0d want 01/255", {if_f.out_valid, done_f}, drop_f);
    end
  endtask

  task automatic test_mid_reset();
    logic [72:0] got, want;
    logic [80:0] got_r;
    int cyc;
    rand_csr(); snap = csr_in; load_beats(MASK_F);
    if_f.out_ready = 1; cap_f = 1;
    @(negedge clk);
    cap_f = 0; cyc = 0;
    while (exp_q[0] != 10 && cyc < 40) begin
      void'(exp_q.pop_front()); cyc++;
      @(negedge clk);
    end
    n_cmp++;
    if (if_f.out_index !== 5'd10) begin
      n_bad++; $display("FAIL midrst_pos got %0d want 10", if_f.out_index);
    end
    #2 rstn = 1'b0;
    #1;
    got_r = {if_f.out_valid, if_f.out_index, if_f.out_data, if_f.out_last, busy_f, done_f, drop_f};
    n_cmp++;
    if (got_r !== '0) begin
      n_bad++; $display("FAIL midrst_async got %h want 0", got_r);
    end
    exp_drop = 0;
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({if_f.out_valid, busy_f, done_f} !== 3'b000) begin
        n_bad++; $display("FAIL midrst_quiet%0d got %b want 000", k, {if_f.out_valid, busy_f, done_f});
      end
    end
    rand_csr(); snap = csr_in; load_beats(MASK_F);
    cap_f = 1;
    @(negedge clk);
    cap_f = 0;
    got  = {if_f.out_valid, if_f.out_index, if_f.out_data, if_f.out_last, busy_f, done_f};
    want = {1'b1, 5'd0, snap[0], 1'b0, 1'b1, 1'b0};
    n_cmp++;
    if (got !== want) begin
      n_bad++; $display("FAIL midrst_restart got %h want %h", got, want);
    end
    $display("midrst: restarted idx=%0d data=%h", if_f.out_index, if_f.out_data);
  endtask

  initial begin
    test_reset();
    test_full_stream();
    test_sparse_mask();
    test_empty_mask();
    test_stall_random();
    test_back_to_back();
    test_drop_saturate();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
